// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the fp32 add/sub scheduler:
//   FP_W     - width of one fp32 operand/result word
//   state_t  - scheduler FSM state encoding
//   op_lsb() - LSB position of requester idx's word inside a packed operand bus
// -----------------------------------------------------------------------------
package fp_pkg;

   localparam int FP_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Requester idx owns bits [FP_W*idx + FP_W-1 : FP_W*idx] of req_a/req_b.
   function automatic int op_lsb(input int idx);
      return idx * FP_W;
   endfunction

endpackage

// File: rtl/fp_addsub_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational NREQ-way round-robin pick. Searches req_valid starting at
// index ptr and wrapping around; the first set bit wins.
// Ports:
//   req_valid  in  NREQ  request vector
//   ptr        in  IW    highest-priority index for this pick
//   grant      out NREQ  one-hot grant (all 0 when nothing is requested)
//   grant_idx  out IW    binary index of the granted requester
//   any_valid  out 1     at least one request bit is set
// -----------------------------------------------------------------------------
module rr_arbiter
   import fp_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IW   = $clog2(NREQ)
)(
   input  logic [NREQ-1:0] req_valid,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   grant_idx,
   output logic            any_valid
);

   always_comb begin
      int          w_idx;
      logic [IW-1:0] w_pos;
      logic        w_found;
      grant     = '0;
      grant_idx = '0;
      any_valid = |req_valid;
      w_found   = 1'b0;
      w_idx     = 0;
      w_pos     = '0;
      for (int k = 0; k < NREQ; k++) begin
         // Modulo by subtraction so non-power-of-two NREQ wraps correctly.
         w_idx = int'(ptr) + k;
         if (w_idx >= NREQ) begin
            w_idx = w_idx - NREQ;
         end
         w_pos = IW'(w_idx);
         if (!w_found && req_valid[w_pos]) begin
            w_found          = 1'b1;
            grant[w_pos]     = 1'b1;
            grant_idx        = w_pos;
         end
      end
   end

endmodule

// File: rtl/fp_addsub_sched.sv
// -----------------------------------------------------------------------------
// fp_addsub_sched
// Round-robin sequencer sharing one external combinational fp32 add/sub unit
// among NREQ requesters. A granted operand pair is held on the unit for LAT
// cycles, the result and flags are captured, and the response is held until
// the owning requester accepts it. No arithmetic is done here.
// Parameters:
//   NREQ  number of requesters (2..8)
//   LAT   cycles operands are held on the unit before sampling (1..15)
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       per-requester operation handshake
//   req_a/req_b               packed operands, requester i at [32i+31:32i]
//   req_sub                   per-requester 1 = A-B, 0 = A+B
//   rsp_valid/rsp_ready       one-hot response handshake to the owner
//   rsp_s, rsp_over/underflag result word and flags of the current response
//   au_a/au_b/au_sub          operands driven to the shared unit
//   au_s/au_over/au_under     result returned by the shared unit
//   busy                      high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module fp_addsub_sched
   import fp_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int LAT  = 1
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [FP_W*NREQ-1:0] req_a,
   input  logic [FP_W*NREQ-1:0] req_b,
   input  logic [NREQ-1:0]      req_sub,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [FP_W-1:0]      rsp_s,
   output logic                 rsp_overflag,
   output logic                 rsp_underflag,
   output logic [FP_W-1:0]      au_a,
   output logic [FP_W-1:0]      au_b,
   output logic                 au_sub,
   input  logic [FP_W-1:0]      au_s,
   input  logic                 au_over,
   input  logic                 au_under,
   output logic                 busy
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = 4;

   state_t            r_state;
   logic [IW-1:0]     r_ptr;
   logic [IW-1:0]     r_own;
   logic [CW-1:0]     r_cnt;
   logic [FP_W-1:0]   r_au_a;
   logic [FP_W-1:0]   r_au_b;
   logic              r_au_sub;
   logic [NREQ-1:0]   r_rsp_valid;
   logic [FP_W-1:0]   r_rsp_s;
   logic              r_rsp_over;
   logic              r_rsp_under;

   logic [NREQ-1:0]   w_grant;
   logic [IW-1:0]     w_gidx;
   logic              w_any;
   logic [NREQ-1:0]   w_own_onehot;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .req_valid (req_valid),
      .ptr       (r_ptr),
      .grant     (w_grant),
      .grant_idx (w_gidx),
      .any_valid (w_any)
   );

   assign w_own_onehot = NREQ'(1) << r_own;

   // Grant is offered only from IDLE; while rst is high nothing is accepted.
   assign req_ready = (r_state == IDLE && w_any && !rst) ? w_grant : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_own       <= '0;
         r_cnt       <= '0;
         r_au_a      <= '0;
         r_au_b      <= '0;
         r_au_sub    <= 1'b0;
         r_rsp_valid <= '0;
         r_rsp_s     <= '0;
         r_rsp_over  <= 1'b0;
         r_rsp_under <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               // Any valid bit means the arbiter's grant handshakes this cycle.
               if (w_any) begin
                  r_au_a   <= req_a[op_lsb(int'(w_gidx)) +: FP_W];
                  r_au_b   <= req_b[op_lsb(int'(w_gidx)) +: FP_W];
                  r_au_sub <= req_sub[w_gidx];
                  r_own    <= w_gidx;
                  r_cnt    <= CW'(LAT - 1);
                  r_state  <= EXEC;
               end
            end
            EXEC: begin
               // Operands stay on au_* for exactly LAT cycles.
               if (r_cnt == '0) begin
                  r_rsp_s     <= au_s;
                  r_rsp_over  <= au_over;
                  r_rsp_under <= au_under;
                  r_rsp_valid <= w_own_onehot;
                  r_state     <= RESP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready[r_own]) begin
                  r_rsp_valid <= '0;
                  r_ptr       <= (int'(r_own) == NREQ - 1) ? '0 : r_own + 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign au_a          = r_au_a;
   assign au_b          = r_au_b;
   assign au_sub        = r_au_sub;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_s         = r_rsp_s;
   assign rsp_overflag  = r_rsp_over;
   assign rsp_underflag = r_rsp_under;
   assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_fp_addsub_sched.sv
// -----------------------------------------------------------------------------
// tb_fp_addsub_sched
// Directed bench for fp_addsub_sched (NREQ=4, LAT=3). A behavioural fp32
// add/sub model stands in for the shared arithmetic unit. Expected responses
// are queued when a request is issued and compared when the DUT hands the
// response back.
// -----------------------------------------------------------------------------
module tb_fp_addsub_sched;

   localparam int NREQ = 4;
   localparam int LAT  = 3;

   typedef struct {
      int          idx;
      logic [31:0] s;
      logic        ov;
      logic        un;
   } exp_t;

   logic               clk;
   logic               rst;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [32*NREQ-1:0] req_a;
   logic [32*NREQ-1:0] req_b;
   logic [NREQ-1:0]    req_sub;
   logic [NREQ-1:0]    rsp_valid;
   logic [NREQ-1:0]    rsp_ready;
   logic [31:0]        rsp_s;
   logic               rsp_overflag;
   logic               rsp_underflag;
   logic [31:0]        au_a;
   logic [31:0]        au_b;
   logic               au_sub;
   logic [31:0]        au_s;
   logic               au_over;
   logic               au_under;
   logic               busy;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];

   fp_addsub_sched #(
      .NREQ (NREQ),
      .LAT  (LAT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_a         (req_a),
      .req_b         (req_b),
      .req_sub       (req_sub),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_s         (rsp_s),
      .rsp_overflag  (rsp_overflag),
      .rsp_underflag (rsp_underflag),
      .au_a          (au_a),
      .au_b          (au_b),
      .au_sub        (au_sub),
      .au_s          (au_s),
      .au_over       (au_over),
      .au_under      (au_under),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Truncating fp32 add/sub; denormal inputs read as zero, overflow gives
   // infinity, underflow gives signed zero. Returns {over, under, s}.
   function automatic logic [33:0] fp_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic sub);
      logic        sa, sb, st;
      int          ea, eb, et, e, d;
      logic [26:0] ma, mb, mt;
      logic [27:0] m;
      sa = a[31];
      sb = b[31] ^ sub;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      ma = (ea != 0) ? {1'b1, a[22:0], 3'b000} : 27'd0;
      mb = (eb != 0) ? {1'b1, b[22:0], 3'b000} : 27'd0;
      if ({b[30:23], mb} > {a[30:23], ma}) begin
         st = sa; sa = sb; sb = st;
         et = ea; ea = eb; eb = et;
         mt = ma; ma = mb; mb = mt;
      end
      d  = ea - eb;
      mb = (d >= 27) ? 27'd0 : (mb >> d);
      m  = (sa == sb) ? ({1'b0, ma} + {1'b0, mb}) : ({1'b0, ma} - {1'b0, mb});
      if (m == 28'd0) return 34'd0;
      e = ea;
      if (m[27]) begin
         m = m >> 1;
         e = e + 1;
      end
      for (int k = 0; k < 27 && !m[26]; k++) begin
         m = m << 1;
         e = e - 1;
      end
      if (e >= 255) return {1'b1, 1'b0, sa, 8'hFF, 23'd0};
      if (e <= 0)   return {1'b0, 1'b1, sa, 31'd0};
      return {2'b00, sa, e[7:0], m[25:3]};
   endfunction

   always_comb begin
      {au_over, au_under, au_s} = fp_model(au_a, au_b, au_sub);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int i, input logic [31:0] s, input logic ov, input logic un);
      exp_t e;
      e.idx = i;
      e.s   = s;
      e.ov  = ov;
      e.un  = un;
      sb_q.push_back(e);
   endtask

   task automatic check_all_zero();
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_s", rsp_s, 0);
      check("rst_rsp_over", rsp_overflag, 0);
      check("rst_rsp_under", rsp_underflag, 0);
      check("rst_au_a", au_a, 0);
      check("rst_au_b", au_b, 0);
      check("rst_au_sub", au_sub, 0);
      check("rst_busy", busy, 0);
   endtask

   // Issue one request, check operand hold during EXEC and response latency.
   // Returns at the negedge on which rsp_valid[i] is first seen.
   task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] es, input logic eo,
                        input logic eu);
      bit seen;
      push_exp(i, es, eo, eu);
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
      req_sub[i]        = sub;
      req_valid[i]      = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
         @(negedge clk);
         seen = req_ready[i];
      end
      check("req_granted", seen, 1);
      @(posedge clk);
      #1 req_valid[i] = 1'b0;
      seen = 1'b0;
      for (int n = 1; n <= 50 && !seen; n++) begin
         @(negedge clk);
         if (rsp_valid[i]) begin
            seen = 1'b1;
            check("rsp_latency", n, LAT + 1);
         end else begin
            check("au_a_hold", au_a, a);
            check("au_b_hold", au_b, b);
            check("au_sub_hold", au_sub, sub);
         end
      end
      check("rsp_seen", seen, 1);
   endtask

   task automatic drain();
      for (int n = 0; n < 200 && sb_q.size() != 0; n++) begin
         @(negedge clk);
      end
      check("drain_empty", sb_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Response scoreboard and per-cycle protocol checks.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         check("req_ready_onehot", ($countones(req_ready) <= 1), 1);
         if (busy) check("req_ready_busy", req_ready, 0);
         if ((rsp_valid & rsp_ready) != '0) begin
            if (sb_q.size() == 0) begin
               check("unexpected_rsp", rsp_valid, 0);
            end else begin
               e = sb_q.pop_front();
               check("rsp_owner", rsp_valid, 64'(1) << e.idx);
               check("rsp_s", rsp_s, e.s);
               check("rsp_over", rsp_overflag, e.ov);
               check("rsp_under", rsp_underflag, e.un);
            end
         end
      end
   end

   initial begin
      bit seen;
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_sub   = '0;
      rsp_ready = '1;
      #2;
      check_all_zero();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // Single add on requester 0: 1.0 + 2.0 = 3.0
      issue(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0);
      drain();

      // Subtract on requester 2: 3.0 - 1.0 = 2.0
      issue(2, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0);
      drain();

      // Reset mid-EXEC on requester 1 (pointer currently 3)
      req_a[32 +: 32] = 32'h40800000;
      req_b[32 +: 32] = 32'h3F800000;
      req_valid[1]    = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
         @(negedge clk);
         seen = req_ready[1];
      end
      check("abort_req_granted", seen, 1);
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      @(negedge clk);
      check("abort_busy_exec", busy, 1);
      #2 rst = 1'b1;
      #1;
      check_all_zero();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         check("abort_no_rsp", rsp_valid, 0);
      end
      @(posedge clk);
      #1;

      // Contention: all four requesters valid, expected grant order 0,1,2,3,0
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*32 +: 32] = 32'h3F800000;
         req_sub[i]        = 1'b0;
      end
      req_b[0*32 +: 32] = 32'h3F800000;
      req_b[1*32 +: 32] = 32'h40000000;
      req_b[2*32 +: 32] = 32'h40400000;
      req_b[3*32 +: 32] = 32'h40800000;
      push_exp(0, 32'h40000000, 1'b0, 1'b0);
      push_exp(1, 32'h40400000, 1'b0, 1'b0);
      push_exp(2, 32'h40800000, 1'b0, 1'b0);
      push_exp(3, 32'h40A00000, 1'b0, 1'b0);
      push_exp(0, 32'h40000000, 1'b0, 1'b0);
      rsp_ready = '1;
      req_valid = '1;
      for (int n = 0; n < 300 && sb_q.size() != 0; n++) begin
         @(negedge clk);
      end
      req_valid = '0;
      check("contention_done", sb_q.size(), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("contention_idle", busy, 0);

      // Backpressure on requester 1 while requester 0 waits
      rsp_ready         = 4'b1101;
      req_a[0 +: 32]    = 32'h3F800000;
      req_b[0 +: 32]    = 32'h3F800000;
      req_sub[0]        = 1'b0;
      req_valid[0]      = 1'b1;
      issue(1, 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 1'b0, 1'b0);
      push_exp(0, 32'h40000000, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         check("bp_rsp_valid", rsp_valid, 4'b0010);
         check("bp_rsp_s", rsp_s, 32'h40800000);
         check("bp_req_ready", req_ready, 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 rsp_ready[1] = 1'b1;
      @(posedge clk);
      #1;
      check("bp_complete", rsp_valid[1], 0);
      seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
         @(negedge clk);
         seen = req_ready[0];
      end
      check("bp_req0_granted", seen, 1);
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      drain();

      // Flags: overflow to requester 3, underflow to requester 2
      rsp_ready = '1;
      issue(3, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
      drain();
      issue(2, 32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 1'b0, 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
